// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock.
// Zero divisor completes immediately with an all-ones quotient and the dividend as remainder.
module seq_divider #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]       state, state_nxt;
  logic [WIDTH:0]   rem_r, rem_nxt;
  logic [WIDTH-1:0] q_r, q_nxt;
  logic [WIDTH-1:0] d_r, d_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             busy_nxt, done_nxt, dbz_nxt;
  logic [WIDTH-1:0] quotient_nxt, remainder_nxt;

  logic [WIDTH:0]   trial;
  logic [WIDTH+1:0] diff;
  logic             borrow;
  logic [WIDTH:0]   r_step;
  logic [WIDTH-1:0] q_step;

  // One restoring iteration: shift in the next dividend bit, trial-subtract the divisor.
  always_comb begin
    trial  = {rem_r[WIDTH-1:0], q_r[WIDTH-1]};
    diff   = {1'b0, trial} - {2'b00, d_r};
    borrow = diff[WIDTH+1];
    r_step = borrow ? trial : diff[WIDTH:0];
    q_step = {q_r[WIDTH-2:0], ~borrow};
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_nxt     = state;
    rem_nxt       = rem_r;
    q_nxt         = q_r;
    d_nxt         = d_r;
    cnt_nxt       = cnt;
    busy_nxt      = busy;
    done_nxt      = 1'b0;
    dbz_nxt       = div_by_zero;
    quotient_nxt  = quotient;
    remainder_nxt = remainder;

    case (state)
      IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            done_nxt      = 1'b1;
            dbz_nxt       = 1'b1;
            quotient_nxt  = '1;
            remainder_nxt = dividend;
          end else begin
            rem_nxt   = '0;
            q_nxt     = dividend;
            d_nxt     = divisor;
            cnt_nxt   = CNT_W'(WIDTH - 1);
            dbz_nxt   = 1'b0;
            busy_nxt  = 1'b1;
            state_nxt = RUN;
          end
        end
      end
      RUN: begin
        rem_nxt = r_step;
        q_nxt   = q_step;
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == '0) begin
          quotient_nxt  = q_step;
          remainder_nxt = r_step[WIDTH-1:0];
          done_nxt      = 1'b1;
          busy_nxt      = 1'b0;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rem_r       <= '0;
      q_r         <= '0;
      d_r         <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
    end else begin
      state       <= state_nxt;
      rem_r       <= rem_nxt;
      q_r         <= q_nxt;
      d_r         <= d_nxt;
      cnt         <= cnt_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      div_by_zero <= dbz_nxt;
      quotient    <= quotient_nxt;
      remainder   <= remainder_nxt;
    end
  end

endmodule
